// File: rtl/memory_responder.sv
// memory_responder: terminates the CPU instruction and data valid/ready ports
// on one shared single-port 32-bit word RAM. Each port's request is captured into
// a one-entry latch. An FSM (IDLE -> WAIT -> RESP) grants one port at a time,
// counts the programmable wait states, performs the byte-strobed access and
// pulses that port's ready for one cycle.
// Latency: a request seen by an idle responder completes wait_states+1 cycles
// later, and at most one access finishes every wait_states+2 cycles.
// Backpressure: none. A port holds at most one outstanding request, and a valid
// that arrives while that port's latch is full or its access is in WAIT is dropped.
// Ports: clock, reset (synchronous, active-high), imemory_* / dmemory_* request
// (valid, instr, addr, wdata, wstrb) and response (rdata, ready).
// Build option: MEMORY_RESPONDER_FAIR_EN selects round-robin arbitration.
// The default build gives the data port fixed priority.
module memory_responder #(
  parameter int addr_bits   = 14,
  parameter int wait_states = 0
) (
  input  logic        clock,
  input  logic        reset,
  input  logic        imemory_valid,
  input  logic        imemory_instr,
  input  logic [31:0] imemory_addr,
  input  logic [31:0] imemory_wdata,
  input  logic [3:0]  imemory_wstrb,
  output logic [31:0] imemory_rdata,
  output logic        imemory_ready,
  input  logic        dmemory_valid,
  input  logic        dmemory_instr,
  input  logic [31:0] dmemory_addr,
  input  logic [31:0] dmemory_wdata,
  input  logic [3:0]  dmemory_wstrb,
  output logic [31:0] dmemory_rdata,
  output logic        dmemory_ready
);

  // Wait-state count, saturated to the 4-bit counter range.
  localparam int          WS    = (wait_states > 15) ? 15 : ((wait_states < 0) ? 0 : wait_states);
  localparam logic [3:0]  WS4   = 4'(WS);
  localparam int          WORDS = 1 << addr_bits;

  typedef enum logic [1:0] {IDLE, WAIT, RESP} state_t;

  state_t               state;
  logic [3:0]           cnt;
  logic [31:0]          mem [WORDS];

  // Per-port request latches.
  logic                 i_pend, d_pend;
  logic [addr_bits-1:0] i_idx, d_idx;
  logic [31:0]          i_wdata, d_wdata;
  logic [3:0]           i_wstrb, d_wstrb;

  // The request in service.
  logic                 act_d;
  logic [addr_bits-1:0] act_idx;
  logic [31:0]          act_wdata;
  logic [3:0]           act_wstrb;

`ifdef MEMORY_RESPONDER_FAIR_EN
  logic                 rr_d;  // 1: the data port is preferred on the next tie
`endif

  logic                 i_req, d_req, grant, grant_d, do_acc, acc_d, cap_i, cap_d;
  logic [addr_bits-1:0] i_sel_idx, d_sel_idx, g_idx, acc_idx;
  logic [31:0]          i_sel_wdata, d_sel_wdata, g_wdata, acc_wdata;
  logic [3:0]           i_sel_wstrb, d_sel_wstrb, g_wstrb, acc_wstrb;
  logic                 unused_ok;

  assign unused_ok = ^{imemory_instr, dmemory_instr, imemory_addr, dmemory_addr};

  always_comb begin
    // A latched request wins over the live inputs, because a live valid
    // against a full latch is a protocol error.
    i_req       = i_pend | imemory_valid;
    d_req       = d_pend | dmemory_valid;
    i_sel_idx   = i_pend ? i_idx   : imemory_addr[addr_bits+1:2];
    i_sel_wdata = i_pend ? i_wdata : imemory_wdata;
    i_sel_wstrb = i_pend ? i_wstrb : imemory_wstrb;
    d_sel_idx   = d_pend ? d_idx   : dmemory_addr[addr_bits+1:2];
    d_sel_wdata = d_pend ? d_wdata : dmemory_wdata;
    d_sel_wstrb = d_pend ? d_wstrb : dmemory_wstrb;
`ifdef MEMORY_RESPONDER_FAIR_EN
    grant_d     = d_req & (~i_req | rr_d);
`else
    grant_d     = d_req;
`endif
    grant       = (state == IDLE) & (i_req | d_req);
    g_idx       = grant_d ? d_sel_idx   : i_sel_idx;
    g_wdata     = grant_d ? d_sel_wdata : i_sel_wdata;
    g_wstrb     = grant_d ? d_sel_wstrb : i_sel_wstrb;
    // With no wait states the granted request is served directly from the
    // arbiter output in the same cycle. Otherwise it is served from the
    // active register when the countdown expires.
    acc_d       = (state == IDLE) ? grant_d : act_d;
    acc_idx     = (state == IDLE) ? g_idx   : act_idx;
    acc_wdata   = (state == IDLE) ? g_wdata : act_wdata;
    acc_wstrb   = (state == IDLE) ? g_wstrb : act_wstrb;
    do_acc      = (grant & (WS4 == 4'd0)) | ((state == WAIT) & (cnt == 4'd0));
    cap_i       = imemory_valid & ~i_pend & ~(grant & ~grant_d) & ~((state == WAIT) & ~act_d);
    cap_d       = dmemory_valid & ~d_pend & ~(grant & grant_d) & ~((state == WAIT) & act_d);
  end

  // The RAM is not reset. The write lands on the edge that starts the ready
  // cycle, so a read issued afterwards sees the new data.
  always_ff @(posedge clock) begin
    if (!reset && do_acc && acc_wstrb != 4'd0) begin
      for (int b = 0; b < 4; b++) begin
        if (acc_wstrb[b]) mem[acc_idx][8*b +: 8] <= acc_wdata[8*b +: 8];
      end
    end
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      state         <= IDLE;
      cnt           <= 4'd0;
      i_pend        <= 1'b0;
      d_pend        <= 1'b0;
      i_idx         <= '0;
      d_idx         <= '0;
      i_wdata       <= '0;
      d_wdata       <= '0;
      i_wstrb       <= '0;
      d_wstrb       <= '0;
      act_d         <= 1'b0;
      act_idx       <= '0;
      act_wdata     <= '0;
      act_wstrb     <= '0;
      imemory_ready <= 1'b0;
      dmemory_ready <= 1'b0;
      imemory_rdata <= '0;
      dmemory_rdata <= '0;
`ifdef MEMORY_RESPONDER_FAIR_EN
      rr_d          <= 1'b1;
`endif
    end else begin
      imemory_ready <= 1'b0;
      dmemory_ready <= 1'b0;
      imemory_rdata <= '0;
      dmemory_rdata <= '0;
      if (cap_i) begin
        i_pend  <= 1'b1;
        i_idx   <= imemory_addr[addr_bits+1:2];
        i_wdata <= imemory_wdata;
        i_wstrb <= imemory_wstrb;
      end
      if (cap_d) begin
        d_pend  <= 1'b1;
        d_idx   <= dmemory_addr[addr_bits+1:2];
        d_wdata <= dmemory_wdata;
        d_wstrb <= dmemory_wstrb;
      end
      case (state)
        IDLE: begin
          if (grant) begin
            act_d     <= grant_d;
            act_idx   <= g_idx;
            act_wdata <= g_wdata;
            act_wstrb <= g_wstrb;
            if (grant_d) d_pend <= 1'b0;
            else         i_pend <= 1'b0;
`ifdef MEMORY_RESPONDER_FAIR_EN
            rr_d      <= ~grant_d;
`endif
            if (WS4 == 4'd0) begin
              state <= RESP;
              cnt   <= 4'd0;
            end else begin
              state <= WAIT;
              cnt   <= WS4 - 4'd1;
            end
          end
        end
        WAIT: begin
          if (cnt == 4'd0) state <= RESP;
          else             cnt   <= cnt - 4'd1;
        end
        default: state <= IDLE;  // RESP: always passes back through IDLE
      endcase
      // Response registers are loaded on the edge that enters RESP. Ready and
      // rdata are therefore high exactly for the RESP cycle.
      if (do_acc) begin
        if (acc_d) begin
          dmemory_ready <= 1'b1;
          if (acc_wstrb == 4'd0) dmemory_rdata <= mem[acc_idx];
        end else begin
          imemory_ready <= 1'b1;
          if (acc_wstrb == 4'd0) imemory_rdata <= mem[acc_idx];
        end
      end
    end
  end

endmodule

// File: tb/tb_memory_responder.sv
// Testbench for memory_responder. Two instances are driven: instance 0 has
// addr_bits=4 and wait_states=0, and instance 1 has addr_bits=6 and wait_states=3.
// Responses are compared with a word-array model and latency/arbitration rules.
module tb_memory_responder;
  logic        clk = 1'b0;
  always #5 clk = ~clk;

  logic        rst [2];
  logic        iv [2], ii [2], dv [2], di [2];
  logic [31:0] ia [2], iw [2], da [2], dw [2];
  logic [3:0]  is_ [2], ds [2];
  logic [31:0] ird [2], drd [2];
  logic        ir [2], dr [2];

  memory_responder #(.addr_bits(4), .wait_states(0)) u_a (
    .clock(clk), .reset(rst[0]),
    .imemory_valid(iv[0]), .imemory_instr(ii[0]), .imemory_addr(ia[0]), .imemory_wdata(iw[0]),
    .imemory_wstrb(is_[0]), .imemory_rdata(ird[0]), .imemory_ready(ir[0]),
    .dmemory_valid(dv[0]), .dmemory_instr(di[0]), .dmemory_addr(da[0]), .dmemory_wdata(dw[0]),
    .dmemory_wstrb(ds[0]), .dmemory_rdata(drd[0]), .dmemory_ready(dr[0]));

  memory_responder #(.addr_bits(6), .wait_states(3)) u_b (
    .clock(clk), .reset(rst[1]),
    .imemory_valid(iv[1]), .imemory_instr(ii[1]), .imemory_addr(ia[1]), .imemory_wdata(iw[1]),
    .imemory_wstrb(is_[1]), .imemory_rdata(ird[1]), .imemory_ready(ir[1]),
    .dmemory_valid(dv[1]), .dmemory_instr(di[1]), .dmemory_addr(da[1]), .dmemory_wdata(dw[1]),
    .dmemory_wstrb(ds[1]), .dmemory_rdata(drd[1]), .dmemory_ready(dr[1]));

  int          vectors = 0;
  int          miscompares = 0;
  int          sz [2] = '{16, 64};
  int          ws [2] = '{0, 3};
  logic [31:0] mdl [2][64];
  bit          pref_d [2];

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    vectors++;
    if (got !== exp) begin
      miscompares++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  // Reference memory: each address maps to word (addr/4) mod size. A write
  // replaces the enabled bytes and returns 0. A read returns the stored word.
  task automatic model_apply(input int u, input logic [31:0] a, input logic [31:0] w,
                             input logic [3:0] s, output logic [31:0] exp);
    int idx;
    idx = int'((a >> 2) % 32'(sz[u]));
    if (s == 4'd0) exp = mdl[u][idx];
    else begin
      for (int b = 0; b < 4; b++)
        if (s[b]) mdl[u][idx][8*b +: 8] = w[8*b +: 8];
      exp = 32'd0;
    end
  endtask

  task automatic set_req(input int u, input bit p, input bit v, input logic [31:0] a,
                         input logic [31:0] w, input logic [3:0] s);
    if (p) begin dv[u] = v; di[u] = 1'($urandom); da[u] = a; dw[u] = w; ds[u] = s; end
    else   begin iv[u] = v; ii[u] = 1'($urandom); ia[u] = a; iw[u] = w; is_[u] = s; end
  endtask

  function automatic bit rdy(input int u, input bit p);
    return p ? dr[u] : ir[u];
  endfunction

  function automatic logic [31:0] rd(input int u, input bit p);
    return p ? drd[u] : ird[u];
  endfunction

  // One request on one port of an idle responder.
  task automatic access(input int u, input bit p, input logic [31:0] a, input logic [31:0] w,
                        input logic [3:0] s, input string tag);
    logic [31:0] exp, got;
    int lat, pulses, other;
    model_apply(u, a, w, s, exp);
    @(posedge clk); #1;
    set_req(u, p, 1'b1, a, w, s);
    lat = 0; pulses = 0; other = 0; got = '0;
    for (int k = 1; k <= ws[u] + 4; k++) begin
      @(posedge clk); #1;
      set_req(u, p, 1'b0, 32'd0, 32'd0, 4'd0);
      @(negedge clk);
      if (rdy(u, p)) begin
        pulses++;
        if (lat == 0) begin lat = k; got = rd(u, p); end
      end
      if (rdy(u, !p) || rd(u, !p) != 32'd0) other++;
    end
    check({tag, "_lat"}, 32'(lat), 32'(ws[u] + 1));
    check({tag, "_rdata"}, got, exp);
    check({tag, "_pulses"}, 32'(pulses), 32'd1);
    check({tag, "_other"}, 32'(other), 32'd0);
    pref_d[u] = !p;
  endtask

  // Both ports request in the same cycle.
  task automatic contend(input int u, input logic [31:0] a0, input logic [31:0] w0, input logic [3:0] s0,
                         input logic [31:0] a1, input logic [31:0] w1, input logic [3:0] s1, input string tag);
    logic [31:0] e [2], g [2];
    int lat [2];
    int both;
    bit win;
`ifdef MEMORY_RESPONDER_FAIR_EN
    win = pref_d[u];
`else
    win = 1'b1;
`endif
    if (win) begin model_apply(u, a1, w1, s1, e[1]); model_apply(u, a0, w0, s0, e[0]); end
    else     begin model_apply(u, a0, w0, s0, e[0]); model_apply(u, a1, w1, s1, e[1]); end
    @(posedge clk); #1;
    set_req(u, 1'b0, 1'b1, a0, w0, s0);
    set_req(u, 1'b1, 1'b1, a1, w1, s1);
    lat = '{0, 0}; g = '{32'd0, 32'd0}; both = 0;
    for (int k = 1; k <= 2 * ws[u] + 6; k++) begin
      @(posedge clk); #1;
      set_req(u, 1'b0, 1'b0, 32'd0, 32'd0, 4'd0);
      set_req(u, 1'b1, 1'b0, 32'd0, 32'd0, 4'd0);
      @(negedge clk);
      if (ir[u] && dr[u]) both++;
      for (int p = 0; p < 2; p++)
        if (rdy(u, p[0]) && lat[p] == 0) begin lat[p] = k; g[p] = rd(u, p[0]); end
    end
    check({tag, "_win_lat"}, 32'(lat[win]), 32'(ws[u] + 1));
    check({tag, "_lose_lat"}, 32'(lat[!win]), 32'(2 * ws[u] + 3));
    check({tag, "_d_rdata"}, g[1], e[1]);
    check({tag, "_i_rdata"}, g[0], e[0]);
    check({tag, "_both"}, 32'(both), 32'd0);
    pref_d[u] = win;
  endtask

  initial begin
    logic [31:0] a, w, a2, w2;
    logic [3:0]  s, s2;
    int          u, pulses;
    bit          p;
    for (int k = 0; k < 2; k++) begin
      rst[k] = 1'b1;
      pref_d[k] = 1'b1;
      set_req(k, 1'b0, 1'b0, 32'd0, 32'd0, 4'd0);
      set_req(k, 1'b1, 1'b0, 32'd0, 32'd0, 4'd0);
    end
    repeat (3) @(posedge clk);
    @(negedge clk);
    for (int k = 0; k < 2; k++) begin
      check("rst_iready", 32'(ir[k]), 32'd0);
      check("rst_dready", 32'(dr[k]), 32'd0);
      check("rst_irdata", ird[k], 32'd0);
      check("rst_drdata", drd[k], 32'd0);
    end
    @(posedge clk); #1;
    rst[0] = 1'b0; rst[1] = 1'b0;

    // Fill both RAMs so every model word is defined.
    for (int k = 0; k < 2; k++)
      for (int i = 0; i < sz[k]; i++)
        access(k, 1'($urandom), 32'(i * 4), $urandom, 4'hF, "init");

    // Directed cases.
    access(0, 1'b1, 32'h10, 32'hDEADBEEF, 4'hF, "wr10");
    access(0, 1'b1, 32'h10, 32'h0, 4'h0, "rd10");
    access(0, 1'b1, 32'h20, 32'h11223344, 4'hF, "strb_init");
    access(0, 1'b1, 32'h20, 32'hAABBCCDD, 4'h5, "strb_wr");
    access(0, 1'b0, 32'h20, 32'h0, 4'h0, "strb_rd");
    check("strb_model", mdl[0][8], 32'h11BB33DD);
    access(0, 1'b1, 32'h40, 32'h5A5A5A5A, 4'hF, "wrap_wr");
    access(0, 1'b0, 32'h00, 32'h0, 4'h0, "wrap_rd");
    access(1, 1'b0, 32'h8, 32'h0, 4'h0, "ws3_rd");
    contend(0, 32'h4, 32'h0, 4'h0, 32'h4, 32'hCAFEF00D, 4'hF, "contend_raw");

    // Reset while the write is in WAIT: the write and its ready are lost.
    a = 32'h24;
    @(posedge clk); #1;
    set_req(1, 1'b1, 1'b1, a, 32'h01020304, 4'hF);
    @(posedge clk); #1;
    set_req(1, 1'b1, 1'b0, 32'd0, 32'd0, 4'd0);
    pulses = 0;
    @(negedge clk); if (dr[1] || ir[1]) pulses++;
    @(posedge clk); #1;
    rst[1] = 1'b1;
    @(posedge clk); #1;
    rst[1] = 1'b0;
    pref_d[1] = 1'b1;
    for (int k = 0; k < 8; k++) begin
      @(negedge clk); if (dr[1] || ir[1]) pulses++;
    end
    check("rst_wait_noready", 32'(pulses), 32'd0);
    access(1, 1'b0, a, 32'h0, 4'h0, "rst_wait_rd");

    // Randomized single requests and contention.
    for (int n = 0; n < 60; n++) begin
      u = int'($urandom_range(1, 0));
      p = 1'($urandom);
      s = $urandom_range(1, 0) ? 4'h0 : 4'($urandom);
      access(u, p, $urandom, $urandom, s, "rnd");
    end
    for (int n = 0; n < 20; n++) begin
      u = int'($urandom_range(1, 0));
      a = 32'($urandom_range(15, 0)) << 2; w = $urandom; s = $urandom_range(1, 0) ? 4'h0 : 4'($urandom);
      a2 = 32'($urandom_range(15, 0)) << 2; w2 = $urandom; s2 = $urandom_range(1, 0) ? 4'h0 : 4'($urandom);
      contend(u, a, w, s, a2, w2, s2, "rnd_contend");
    end

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end
endmodule
